// File: rtl/regfile_pkg.sv
// Shared types, default geometry and helpers for the parametrised register file.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W    = 32;
    localparam int RF_NREGS     = 16;
    localparam int RF_PC_IDX    = 15;
    localparam int RF_PC_OFFSET = 8;

    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: PC alias, range check, write bypass, storage mux.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int NREGS     = RF_NREGS,
    parameter int PC_IDX    = RF_PC_IDX,
    parameter int PC_OFFSET = RF_PC_OFFSET,
    parameter int AW        = rf_aw(RF_NREGS)
) (
    input  logic [AW-1:0]     ra,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              byp_en,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [DATA_W-1:0] regs [NREGS],
    output logic [DATA_W-1:0] rd
);

    logic [31:0] ra_ext;

    assign ra_ext = 32'(ra);

    // PC alias outranks everything, so a PC_IDX beyond NREGS still reads the PC.
    always_comb begin
        rd = '0;
        if (ra_ext == 32'(PC_IDX)) begin
            rd = pc_in + DATA_W'(PC_OFFSET);
        end else if (ra_ext >= 32'(NREGS)) begin
            rd = '0;
        end else if (byp_en && (wa == ra)) begin
            rd = wd;
        end else begin
            rd = regs[ra];
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with PC alias, write bypass, pending-write
// scoreboard and a sequenced soft-clear engine.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int  DATA_W    = RF_DATA_W,
    parameter int  NREGS     = RF_NREGS,
    parameter int  NRD       = 2,
    parameter int  PC_IDX    = RF_PC_IDX,
    parameter int  PC_OFFSET = RF_PC_OFFSET,
    localparam int AW        = rf_aw(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*DATA_W-1:0] rd,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  iss_v,
    input  logic [AW-1:0]         iss_idx,
    output logic [NREGS-1:0]      busy,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  pc_wr_err
);

    rf_state_e         state_q, state_d;
    logic [AW-1:0]     cidx_q, cidx_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic              pc_wr_err_q;

    logic in_idle, wa_is_pc, wa_in_rng, wr_ok, iss_ok, byp_en;

    assign in_idle   = (state_q == RF_IDLE);
    assign wa_is_pc  = (32'(wa) == 32'(PC_IDX));
    assign wa_in_rng = (32'(wa) < 32'(NREGS));
    assign wr_ok     = we && in_idle && wa_in_rng && !wa_is_pc;
    assign iss_ok    = iss_v && in_idle && (32'(iss_idx) < 32'(NREGS))
                       && (32'(iss_idx) != 32'(PC_IDX));
    assign byp_en    = we && in_idle && !wa_is_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RF_IDLE;
            cidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cidx_q  <= cidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cidx_d  = cidx_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cidx_d  = '0;
                end
            end
            RF_CLEAR: begin
                if (32'(cidx_q) == 32'(NREGS - 1)) begin
                    state_d = RF_IDLE;
                    cidx_d  = '0;
                end else begin
                    cidx_d = cidx_q + 1'b1;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (state_q == RF_CLEAR);
    end

    // Issue is applied after the write clear so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (!in_idle) begin
                if (cidx_q == AW'(i)) busy_d[i] = 1'b0;
            end else begin
                if (wr_ok && (wa == AW'(i)))       busy_d[i] = 1'b0;
                if (iss_ok && (iss_idx == AW'(i))) busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q      <= '0;
            pc_wr_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            pc_wr_err_q <= we && in_idle && wa_is_pc;
            for (int i = 0; i < NREGS; i++) begin
                if (i != PC_IDX) begin
                    if (!in_idle && (cidx_q == AW'(i))) begin
                        regs_q[i] <= '0;
                    end else if (wr_ok && (wa == AW'(i))) begin
                        regs_q[i] <= wd;
                    end
                end
            end
        end
    end

    assign busy      = busy_q;
    assign pc_wr_err = pc_wr_err_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_rdport #(
            .DATA_W    (DATA_W),
            .NREGS     (NREGS),
            .PC_IDX    (PC_IDX),
            .PC_OFFSET (PC_OFFSET),
            .AW        (AW)
        ) u_rdport (
            .ra     (ra[p*AW +: AW]),
            .pc_in  (pc_in),
            .byp_en (byp_en),
            .wa     (wa),
            .wd     (wd),
            .regs   (regs_q),
            .rd     (rd[p*DATA_W +: DATA_W])
        );
    end

endmodule
